// File: rtl/msb_serial_comparator_if.sv
// Handshake and operand/result bundle for the MSB-first serial comparator.
// The master drives requests and operands; the slave returns status and result.
interface msb_serial_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             g;
    logic             l;

    modport master (
        output start, abort, x, y,
        input  busy, done, g, l
    );

    modport slave (
        input  start, abort, x, y,
        output busy, done, g, l
    );
endinterface

// File: rtl/msb_serial_comparator.sv
// Sequential unsigned magnitude comparator: scans one bit pair per clock, MSB first,
// and stops at the first differing bit with a one-cycle done pulse.
module msb_serial_comparator #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    msb_serial_comparator_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CW-1:0] IDX_TOP = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             g_q, g_d;
    logic             l_q, l_d;

    logic             x_msb;
    logic             y_msb;

    assign x_msb = xs_q[WIDTH-1];
    assign y_msb = ys_q[WIDTH-1];

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        idx_d   = idx_q;
        g_d     = g_q;
        l_d     = l_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xs_d    = bus.x;
                    ys_d    = bus.y;
                    idx_d   = IDX_TOP;
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Abort wins over a compare that would resolve on the same edge.
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (x_msb != y_msb) begin
                    g_d     = x_msb & ~y_msb;
                    l_d     = ~x_msb & y_msb;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    g_d     = 1'b0;
                    l_d     = 1'b0;
                    state_d = DONE;
                end else begin
                    xs_d    = xs_q << 1;
                    ys_d    = ys_q << 1;
                    idx_d   = idx_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        busy_d = (state_d == SCAN);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            g_q     <= 1'b0;
            l_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            g_q     <= g_d;
            l_q     <= l_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.g    = g_q;
    assign bus.l    = l_q;

endmodule

// File: tb/tb_msb_serial_comparator.sv
// Self-checking bench for msb_serial_comparator: a latency/result model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_msb_serial_comparator;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    msb_serial_comparator_if #(.WIDTH(WIDTH)) bus ();

    msb_serial_comparator #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Cycles from the accepting edge to the edge that raises done.
    function automatic int exp_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        for (int j = 0; j < WIDTH; j++) begin
            if (a[WIDTH-1-j] != b[WIDTH-1-j]) return j + 1;
        end
        return WIDTH;
    endfunction

    // Behavioural model: phase 0 idle, 1 scanning, 2 done pulse.
    int   m_phase;
    int   m_rem;
    logic m_g, m_l, m_rg, m_rl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_rem   <= 0;
            m_g     <= 1'b0;
            m_l     <= 1'b0;
            m_rg    <= 1'b0;
            m_rl    <= 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.start) begin
                    m_phase <= 1;
                    m_rem   <= exp_latency(bus.x, bus.y);
                    m_g     <= 1'b0;
                    m_l     <= 1'b0;
                    m_rg    <= (bus.x > bus.y);
                    m_rl    <= (bus.x < bus.y);
                end
                1: if (bus.abort) begin
                    m_phase <= 0;
                end else if (m_rem == 1) begin
                    m_phase <= 2;
                    m_g     <= m_rg;
                    m_l     <= m_rl;
                end else begin
                    m_rem   <= m_rem - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cycle_outputs", {28'd0, bus.busy, bus.done, bus.g, bus.l},
                  {28'd0, (m_phase == 1), (m_phase == 2), m_g, m_l});
        end
    end

    // Runs one comparison from a negedge. Optionally injects a stray start (with new
    // operands) or an abort before edge E<n>. lat = -1 if done never pulses.
    task automatic run(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int start_at, input int abort_at, output int lat,
                       output logic rg, output logic rl);
        bus.start = 1'b1;
        bus.x     = a;
        bus.y     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.x     = ~a;
        bus.y     = ~b;
        check("busy_after_e0", bus.busy, 1);
        check("gl_cleared_e0", {bus.g, bus.l}, 0);
        lat = -1;
        for (int c = 1; c <= 12; c++) begin
            bus.start = (c == start_at);
            bus.abort = (c == abort_at);
            if (c == start_at) begin
                bus.x = 8'hFF;
                bus.y = 8'h00;
            end
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rg = bus.g;
        rl = bus.l;
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("hold_after_done", {bus.g, bus.l}, {rg, rl});
    endtask

    int   lat;
    logic rg, rl;
    logic [WIDTH-1:0] ra, rb;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.x     = 8'hA5;
        bus.y     = 8'h25;

        // 1: reset held with start high, then MSB-differing operands.
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.busy, bus.done, bus.g, bus.l}, 0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        run(8'hA5, 8'h25, 0, 0, lat, rg, rl);
        check("t1_latency", lat, 1);
        check("t1_g", rg, 1);
        check("t1_l", rl, 0);

        // 2: differ only in LSB; g from the previous run must be cleared at E0.
        run(8'h3C, 8'h3D, 0, 0, lat, rg, rl);
        check("t2_latency", lat, 8);
        check("t2_gl", {rg, rl}, 2'b01);

        // 3: equal operands, then MSB-only difference.
        run(8'h5A, 8'h5A, 0, 0, lat, rg, rl);
        check("t3_eq_latency", lat, 8);
        check("t3_eq_gl", {rg, rl}, 2'b00);
        run(8'h00, 8'h80, 0, 0, lat, rg, rl);
        check("t3_latency", lat, 1);
        check("t3_gl", {rg, rl}, 2'b01);

        // 4: stray start with new operands during SCAN is ignored.
        run(8'h01, 8'h00, 3, 0, lat, rg, rl);
        check("t4_latency", lat, 8);
        check("t4_gl", {rg, rl}, 2'b10);

        // 5a: abort before edge E4: no done, g and l stay 0.
        run(8'h10, 8'h11, 0, 4, lat, rg, rl);
        check("t5_abort_no_done", lat, -1);
        check("t5_abort_gl", {rg, rl}, 2'b00);
        check("t5_abort_idle", bus.busy, 0);

        // 5b: asynchronous reset mid-scan, checked between clock edges.
        run(8'hC0, 8'h40, 0, 0, lat, rg, rl);
        check("t5_pre_g", rg, 1);
        bus.start = 1'b1;
        bus.x     = 8'h0F;
        bus.y     = 8'h0E;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("t5_async_reset", {bus.busy, bus.done, bus.g, bus.l}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: random pairs against the integer relation and first-difference latency.
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 8 == 0) ? ra : WIDTH'($urandom);
            run(ra, rb, 0, 0, lat, rg, rl);
            check("rand_latency", lat, exp_latency(ra, rb));
            check("rand_gl", {rg, rl}, {(ra > rb), (ra < rb)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
